// File: rtl/collatz_range_engine.sv
// Collatz range engine: computes sequence lengths for RAM_WORDS consecutive start values into an internal RAM.
// Optional running maximum tracker enabled by defining COLLATZ_MAX_EN.
module collatz_range_engine #(
  parameter int RAM_WORDS     = 256,
  parameter int RAM_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     go,
  input  logic [31:0]              start,
  input  logic [RAM_ADDR_BITS-1:0] n,
  output logic [15:0]              count,
  output logic                     done,
  output logic                     busy,
  output logic [15:0]              max_count,
  output logic [RAM_ADDR_BITS-1:0] max_idx
);

  localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [31:0]                base_q, base_d;
  logic [31:0]                value_q, value_d;
  logic [15:0]                len_q, len_d;
  logic [RAM_ADDR_BITS-1:0]   idx_q, idx_d;
  logic [15:0]                count_q;
  logic [15:0]                len_inc;
  logic [15:0]                fin_len;
  logic [33:0]                triple;
  logic                       finish;
  logic                       accept;
  logic [15:0]                ram_q [RAM_WORDS];

  // 3v+1 kept two bits wider so a 32-bit overflow is visible
  assign triple  = {1'b0, value_q, 1'b0} + {2'b00, value_q} + 34'd1;
  assign len_inc = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
  assign accept  = (state_q == S_IDLE) && go;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    value_d = value_q;
    len_d   = len_q;
    idx_d   = idx_q;
    finish  = 1'b0;
    fin_len = len_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          base_d  = start;
          value_d = start;
          len_d   = 16'd1;
          idx_d   = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (value_q == 32'd0) begin
          finish  = 1'b1;
          fin_len = 16'd0;
        end else if (value_q == 32'd1) begin
          finish  = 1'b1;
          fin_len = len_q;
        end else if (!value_q[0]) begin
          value_d = value_q >> 1;
          len_d   = len_inc;
        end else if (|triple[33:32]) begin
          finish  = 1'b1;
          fin_len = 16'hFFFF;
        end else begin
          value_d = triple[31:0];
          len_d   = len_inc;
        end
        if (finish) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + RAM_ADDR_BITS'(1);
            value_d = base_q + 32'(idx_q) + 32'd1;
            len_d   = 16'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      value_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      value_q <= value_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      count_q <= ram_q[n];
    end
  end

  // Result storage is deliberately not reset so partial runs survive rst_n
  always_ff @(posedge clk) begin
    if (finish) begin
      ram_q[idx_q] <= fin_len;
    end
  end

  assign count = count_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);

`ifdef COLLATZ_MAX_EN
  logic [15:0]              max_count_q;
  logic [RAM_ADDR_BITS-1:0] max_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_count_q <= '0;
      max_idx_q   <= '0;
    end else if (accept) begin
      max_count_q <= '0;
      max_idx_q   <= '0;
    end else if (finish && (fin_len > max_count_q)) begin
      max_count_q <= fin_len;
      max_idx_q   <= idx_q;
    end
  end

  assign max_count = max_count_q;
  assign max_idx   = max_idx_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign max_count     = '0;
  assign max_idx       = '0;
`endif

endmodule

// File: tb/tb_collatz_range_engine.sv
// Directed bench for collatz_range_engine: reference Collatz lengths, run timing, go filtering, reset and readback.
module tb_collatz_range_engine;

  logic        clk;
  logic        rst_n;
  logic        go;
  logic [31:0] start;
  logic [7:0]  n;
  logic [15:0] count;
  logic        done;
  logic        busy;
  logic [15:0] max_count;
  logic [7:0]  max_idx;

  int tests;
  int fails;
  int exp_len [256];
  int cyc;
  int dones;
  int sum_cyc;
  int mx;
  int mx_idx;

  collatz_range_engine #(.RAM_WORDS(256), .RAM_ADDR_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .start     (start),
    .n         (n),
    .count     (count),
    .done      (done),
    .busy      (busy),
    .max_count (max_count),
    .max_idx   (max_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference length: terms counted including the start value; 0 -> 0, 32-bit overflow -> 0xFFFF
  function automatic int clen(input logic [31:0] v);
    longint unsigned x;
    int l;
    if (v == 32'd0) return 0;
    x = 64'(v);
    l = 1;
    while (x != 64'd1) begin
      if (x[0] == 1'b0) begin
        x = x >> 1;
      end else begin
        x = 3 * x + 1;
        if (x > 64'hFFFF_FFFF) return 65535;
      end
      if (l < 65535) l++;
    end
    return l;
  endfunction

  task automatic fill_model(input logic [31:0] base);
    sum_cyc = 0;
    mx = 0;
    mx_idx = 0;
    for (int i = 0; i < 256; i++) begin
      exp_len[i] = clen(base + 32'(i));
      sum_cyc += (exp_len[i] == 0) ? 1 : exp_len[i];
      if (exp_len[i] > mx) begin
        mx = exp_len[i];
        mx_idx = i;
      end
    end
  endtask

  task automatic rd(input int k, input string tag, input int exp_v);
    @(negedge clk);
    n = k[7:0];
    @(posedge clk);
    #1;
    check(tag, {16'd0, count}, exp_v[31:0]);
  endtask

  // Launch a run and count edges from the go-accepting edge until done is seen
  task automatic run(input logic [31:0] s, input bit poke, input int budget,
                     output int cyc_o, output int dones_o);
    bit finished;
    @(negedge clk);
    start = s;
    go = 1'b1;
    cyc_o = 0;
    dones_o = 0;
    finished = 1'b0;
    while (!finished && cyc_o < budget) begin
      @(negedge clk);
      cyc_o++;
      go = 1'b0;
      start = 32'd5;
      if (cyc_o == 1) check("busy_after_go", {31'd0, busy}, 32'd1);
      if (done) begin
        dones_o++;
        finished = 1'b1;
        check("busy_in_done", {31'd0, busy}, 32'd1);
      end else if (poke && (cyc_o % 37 == 5)) begin
        go = 1'b1;
      end
    end
    check("run_completed", {31'd0, finished}, 32'd1);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      go = 1'b0;
      if (done) dones_o++;
    end
    check("idle_after_run", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    go = 1'b0;
    start = 32'd0;
    n = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {16'd0, count}, 32'd0);
    check("rst_max_count", {16'd0, max_count}, 32'd0);
    check("rst_max_idx", {24'd0, max_idx}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // start=1 with ignored go pulses while busy
    fill_model(32'd1);
    run(32'd1, 1'b1, 60000, cyc, dones);
    check("run1_cycles", cyc, sum_cyc + 1);
    check("run1_single_done", dones, 32'd1);
    rd(0, "len_1", 1);
    rd(1, "len_2", 2);
    rd(2, "len_3", 8);
    rd(26, "len_27", 112);
    rd(96, "len_97", 119);
    for (int i = 0; i < 256; i++) begin
      rd(i, $sformatf("sweep1_n%0d", i), exp_len[i]);
    end
`ifdef COLLATZ_MAX_EN
    check("max_count", {16'd0, max_count}, mx);
    check("max_idx", {24'd0, max_idx}, mx_idx);
`else
    check("max_count_tied", {16'd0, max_count}, 32'd0);
    check("max_idx_tied", {24'd0, max_idx}, 32'd0);
`endif

    // Back-to-back address changes: each read lands exactly one cycle later
    rd(5, "lat_n5", clen(32'd6));
    rd(200, "lat_n200", clen(32'd201));
    rd(7, "lat_n7", clen(32'd8));
    rd(170, "lat_n170", clen(32'd171));

    // Zero start value
    fill_model(32'd0);
    run(32'd0, 1'b0, 60000, cyc, dones);
    check("run0_cycles", cyc, sum_cyc + 1);
    rd(0, "len_0", 0);
    rd(1, "len_1_again", 1);

    // Top of range: odd values overflow 3v+1 immediately, last value wraps to 0xFFFFFFFF
    run(32'hFFFF_FF00, 1'b0, 90000, cyc, dones);
    check("runhi_single_done", dones, 32'd1);
    rd(1, "ovf_ffffff01", 32'hFFFF);
    rd(255, "ovf_ffffffff", 32'hFFFF);

    // Reset in the middle of a run, then a fresh run
    @(negedge clk);
    n = 8'd1;
    start = 32'd1;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (600) @(negedge clk);
    check("busy_mid_run", {31'd0, busy}, 32'd1);
    check("count_before_rst", {16'd0, count}, 32'd2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_count", {16'd0, count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    fill_model(32'd1000);
    run(32'd1000, 1'b0, 60000, cyc, dones);
    check("run1000_cycles", cyc, sum_cyc + 1);
    check("run1000_single_done", dones, 32'd1);
    rd(0, "len_1000", 112);
    rd(255, "len_1255", exp_len[255]);
    rd(128, "len_1128", exp_len[128]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
